// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable multi-channel clock divider:
//   MIN_DIV      smallest divisor a channel accepts
//   default_div  reset-default divisor from input/output frequencies in Hz
//   ch_state_e   per-channel run state
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } ch_state_e;

    function automatic int unsigned default_div(input int unsigned in_hz,
                                                input int unsigned out_hz);
        return in_hz / out_hz;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: counts 0..N-1 and produces a near-50% enable-clock
// (high for ceil(N/2) cycles) plus a one-cycle tick at each period start.
// A divisor loaded while running is held pending and applied at the next
// period boundary (wrap or align), so the output never glitches.
// Ports:
//   clk_i       system clock, rising edge
//   rstn_i      synchronous active-low reset
//   en_i        run enable
//   align_i     force a period restart (tie low when unused)
//   load_i      accepted, legal divisor load for this channel
//   load_div_i  divisor carried with load_i
//   pend_o      a divisor is waiting for the next boundary
//   clk_out_o   divided clock, registered
//   tick_o      period-start pulse, registered
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned      DIV_W   = 32,
    parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(MIN_DIV)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             align_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_div_i,
    output logic             pend_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] hi_d;

    // NOTE: every signal gets its default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;

        if (!en_i) begin
            // Disabling aborts the period, which is itself a boundary: a
            // waiting divisor takes effect now, and direct loads apply at once.
            state_d = CH_IDLE;
            cnt_d   = '0;
            if (pend_q) begin
                div_cur_d = div_pend_q;
                pend_d    = 1'b0;
            end
            if (load_i) begin
                div_cur_d = load_div_i;
            end
        end else begin
            state_d = CH_RUN;
            if (state_q == CH_IDLE || align_i || cnt_q == div_cur_q - DIV_W'(1)) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_cur_d = div_pend_q;
                    pend_d    = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            // Boundary logic above only consumes an older pending value, so a
            // load landing on a wrap waits for the following boundary.
            if (load_i) begin
                div_pend_d = load_div_i;
                pend_d     = 1'b1;
            end
        end

        // Outputs follow the new count under the divisor of the new period.
        hi_d      = div_cur_d - (div_cur_d >> 1);
        clk_out_d = en_i && (cnt_d < hi_d);
        tick_d    = en_i && (cnt_d == '0);
    end

    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= CH_IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DEF_DIV;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update from
            // the same pre-edge values, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
// NUM_CH independent programmable clock dividers fed from sys_clk, with a
// valid/ready divisor-load port shared by all channels.
// Optional feature macro: SYNC_ALIGN_EN adds the 'align' input, which restarts
// the period of every enabled channel at once.
// Ports:
//   sys_clk    system clock, rising edge
//   rstn       synchronous active-low reset
//   ch_en      per-channel run enable
//   cfg_valid  divisor load request
//   cfg_ready  load accepted when cfg_valid && cfg_ready (no divisor pending)
//   cfg_ch     target channel
//   cfg_div    new divisor N
//   align      (SYNC_ALIGN_EN only) phase realignment strobe
//   cfg_err    one-cycle pulse: accepted load was illegal and dropped
//   clk_out    divided clocks, registered
//   tick       period-start pulses, registered
// -----------------------------------------------------------------------------
module multi_clock_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned INPUT_CLOCK_FREQUENCY  = 50_000_000,
    parameter int unsigned OUTPUT_CLOCK_FREQUENCY = 1,
    parameter int unsigned NUM_CH                 = 4,
    parameter int unsigned DIV_W                  = 32,
    localparam int         CH_W                   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef SYNC_ALIGN_EN
    input  logic              align,
`endif
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] DEF_DIV =
        DIV_W'(default_div(INPUT_CLOCK_FREQUENCY, OUTPUT_CLOCK_FREQUENCY));

    logic [NUM_CH-1:0]    pend;
    logic [2**CH_W-1:0]   pend_ext;   // pending flags padded to the cfg_ch range
    logic [2**CH_W-1:0]   ch_ok;      // which cfg_ch codes name a real channel
    logic                 accept;
    logic                 load_ok;
    logic                 align_w;
    logic                 cfg_err_q;

`ifdef SYNC_ALIGN_EN
    assign align_w = align;
`else
    assign align_w = 1'b0;
`endif

    always_comb begin
        pend_ext = '0;
        ch_ok    = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            pend_ext[j] = pend[j];
            ch_ok[j]    = 1'b1;
        end
    end

    // Unknown channels never pend, so a load to them is always accepted.
    assign cfg_ready = !pend_ext[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;
    assign load_ok   = accept && ch_ok[cfg_ch] && (cfg_div >= DIV_W'(MIN_DIV));

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= accept && !load_ok;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        clk_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_i      (sys_clk),
            .rstn_i     (rstn),
            .en_i       (ch_en[g]),
            .align_i    (align_w),
            .load_i     (load_ok && (cfg_ch == CH_W'(g))),
            .load_div_i (cfg_div),
            .pend_o     (pend[g]),
            .clk_out_o  (clk_out[g]),
            .tick_o     (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
// Directed bench for a 2-channel, 8-bit divider with a default divisor of 4.
// The driver pushes the expected outputs of each coming edge into a queue; a
// monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;

    logic              sys_clk = 1'b0;
    logic              rstn;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
`ifdef SYNC_ALIGN_EN
    logic              align;
`endif

    typedef struct {
        int          due;
        logic [1:0]  clk;
        logic [1:0]  tck;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    multi_clock_divider #(
        .INPUT_CLOCK_FREQUENCY  (40),
        .OUTPUT_CLOCK_FREQUENCY (10),
        .NUM_CH                 (NUM_CH),
        .DIV_W                  (DIV_W)
    ) dut (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef SYNC_ALIGN_EN
        .align     (align),
`endif
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bit_at(input string s, input int i);
        if (i >= s.len()) return 1'b0;
        return s.getc(i) == "1";
    endfunction

    // Apply current inputs for len(c0) edges, queuing the expected result of
    // each edge. Empty strings mean "all zero".
    task automatic run(input string name, input string c0, input string t0,
                       input string c1, input string t1, input string er);
        for (int i = 0; i < c0.len(); i++) begin
            exp_t e;
            e.due  = cyc + 1;
            e.clk  = {bit_at(c1, i), bit_at(c0, i)};
            e.tck  = {bit_at(t1, i), bit_at(t0, i)};
            e.err  = bit_at(er, i);
            e.name = name;
            sb.push_back(e);
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Monitor: compare every queued expectation due at the latest edge.
    always @(negedge sys_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.name, "/due"},     32'(e.due), 32'(cyc));
            check({e.name, "/clk_out"}, 32'(clk_out), 32'(e.clk));
            check({e.name, "/tick"},    32'(tick), 32'(e.tck));
            check({e.name, "/cfg_err"}, 32'(cfg_err), 32'(e.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        ch_en     = 2'b00;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = '0;
`ifdef SYNC_ALIGN_EN
        align     = 1'b0;
`endif
        @(posedge sys_clk);
        #1;

        // 1: reset, then ch0 runs at the default N=4
        run("reset", "00000", "00000", "", "", "");
        rstn  = 1'b1;
        ch_en = 2'b01;
        check("ready_after_reset", 32'(cfg_ready), 32'd1);
        run("default_n4", "11001100", "10001000", "00000000", "00000000", "");

        // 2: load N=5 into disabled ch1, then enable it
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd5;
        check("ready_ch1_idle", 32'(cfg_ready), 32'd1);
        run("load_idle", "1", "1", "0", "0", "0");
        cfg_valid = 1'b0;
        ch_en     = 2'b11;
        run("odd_n5", "1001100110", "0001000100", "1110011100", "1000010000", "");

        // 3: glitch-free update of running ch0 from 4 to 6
        ch_en = 2'b01;
        run("to_cnt1", "011", "010", "", "", "");
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd6;
        check("ready_ch0_free", 32'(cfg_ready), 32'd1);
        run("load_run", "0", "0", "", "", "");
        cfg_div = 8'd7;
        check("ready_ch0_pending", 32'(cfg_ready), 32'd0);
        run("blocked_load", "0", "0", "", "", "");
        cfg_valid = 1'b0;
        run("n6_applied", "111000111000", "100000100000", "", "", "");
        check("ready_after_wrap", 32'(cfg_ready), 32'd1);

        // 4: illegal divisors are flagged and dropped
        ch_en = 2'b00;
        run("disable", "0", "0", "", "", "");
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        run("reload_n4", "0", "0", "", "", "");
        cfg_div = 8'd1;
        ch_en   = 2'b01;
        run("illegal_n1", "1", "1", "", "", "1");
        cfg_valid = 1'b0;
        run("still_n4", "1001100", "0001000", "", "", "0000000");
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd0;
        run("illegal_n0", "1", "1", "", "", "1");
        cfg_valid = 1'b0;

        // 5: reset mid-period discards the pending N=6
        run("to_cnt1_b", "1", "0", "", "", "");
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd6;
        run("pend_n6", "0", "0", "", "", "");
        cfg_valid = 1'b0;
        rstn      = 1'b0;
        run("mid_reset", "00", "00", "", "", "");
        check("ready_pend_lost", 32'(cfg_ready), 32'd1);
        rstn  = 1'b1;
        ch_en = 2'b11;
        run("post_reset_n4", "11001100", "10001000", "11001100", "10001000", "");

`ifdef SYNC_ALIGN_EN
        // 6: ch0 N=4, ch1 N=6 out of phase, then realign both
        ch_en     = 2'b01;
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd6;
        run("load_ch1_n6", "1", "1", "0", "0", "");
        cfg_valid = 1'b0;
        ch_en     = 2'b11;
        run("free_run", "100", "000", "111", "100", "");
        align = 1'b1;
        run("align", "1", "1", "1", "1", "");
        align = 1'b0;
        run("after_align", "10011", "00010", "11000", "00000", "");
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge sys_clk);
        if (sb.size() > 0) check("drain", 32'(sb.size()), 32'd0);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
